// File: rtl/key_debouncer.sv
// key_debouncer: multi-channel push-button debouncer.
// Each raw active-low button is synchronised into the clock domain.
// It is then accepted as a new debounced level only after the
// synchronised value has disagreed with the current level for
// DEBOUNCE_CYCLES consecutive cycles.
// Debounced levels and one-cycle press/release pulses are all
// registered, so nothing combinational reaches the outputs from key_n.
module key_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  // Counter is just wide enough to hold DEBOUNCE_CYCLES; it never goes
  // past DEBOUNCE_CYCLES-1 because reaching that value with a mismatch
  // flips the level and clears the counter instead.
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync_a;
  logic [NUM_KEYS-1:0] sync_b;
  logic [NUM_KEYS-1:0] key_on;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stable_next;
  logic [CNT_W-1:0]    cnt      [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_next [NUM_KEYS];

  // Two-flop synchroniser; resets to all ones so every key reads as released.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
    end
  end

  assign key_on = ~sync_b;

  // Per-channel stability counter and level update, channels independent.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_next[i] = cnt[i];
      if (key_on[i] == stable[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        stable_next[i] = ~stable[i];
        cnt_next[i]    = '0;
      end else begin
        cnt_next[i] = cnt[i] + 1'b1;
      end
    end
  end

  // State registers and edge pulses, which line up with the level change.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable      <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable      <= stable_next;
      key_press   <= stable_next & ~stable;
      key_release <= ~stable_next & stable;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign key_level = stable;

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scoreboard bench for key_debouncer with DEBOUNCE_CYCLES = 4.
// Stimulus pushes each expected press/release event and the edge it is due on.
// The monitor pops an event for every pulse the DUT shows.
// It also flags pulses nobody expected and events that never arrived.
module tb_key_debouncer;

  localparam int NK  = 4;
  localparam int DC  = 4;
  localparam int LAT = DC + 2;

  logic          clock;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  typedef struct {
    int         at;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
  } ev_t;

  ev_t sb[$];
  int  cyc    = 0;
  int  checks = 0;
  int  fails  = 0;

  key_debouncer #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  // 20 ns clock.
  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Rising-edge counter used to time expected events.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [3:0] kn);
    key_n = kn;
  endtask

  task automatic expectEvent(input int delay, input logic [3:0] p,
                             input logic [3:0] r, input logic [3:0] lvl);
    ev_t e;
    e.at    = cyc + delay;
    e.press = p;
    e.rel   = r;
    e.level = lvl;
    sb.push_back(e);
  endtask

  // Monitor: compare every pulse against the scoreboard and catch late events.
  always @(negedge clock) begin
    ev_t e;
    if ((key_press != '0) || (key_release != '0)) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected pulse: press %b release %b at edge %0d, none expected",
                 key_press, key_release, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("event edge", cyc, e.at);
        checkOutput("event press", int'(key_press), int'(e.press));
        checkOutput("event release", int'(key_release), int'(e.rel));
        checkOutput("event level", int'(key_level), int'(e.level));
      end
    end else if ((sb.size() > 0) && (cyc > sb[0].at)) begin
      e = sb.pop_front();
      checks++;
      fails++;
      $display("[TB] FAIL missing pulse: no pulse by edge %0d, press %b release %b due at edge %0d",
               cyc, e.press, e.rel, e.at);
    end
  end

  initial begin
    reset = 1'b1;
    key_n = 4'b1111;
    waitCycles(3);
    checkOutput("reset level", int'(key_level), 0);
    checkOutput("reset press", int'(key_press), 0);
    checkOutput("reset release", int'(key_release), 0);
    reset = 1'b0;
    waitCycles(4);

    $display("[TB] clean press on key 0");
    applyStimulus(4'b1110);
    expectEvent(LAT, 4'b0001, 4'b0000, 4'b0001);
    waitCycles(LAT - 1);
    checkOutput("level before press edge", int'(key_level), 0);
    waitCycles(5);
    checkOutput("level after press", int'(key_level), 1);

    $display("[TB] release key 0");
    applyStimulus(4'b1111);
    expectEvent(LAT, 4'b0000, 4'b0001, 4'b0000);
    waitCycles(10);
    checkOutput("level after release", int'(key_level), 0);

    $display("[TB] three-cycle glitch on key 1");
    applyStimulus(4'b1101);
    waitCycles(3);
    applyStimulus(4'b1111);
    waitCycles(12);
    checkOutput("level after glitch", int'(key_level), 0);

    $display("[TB] bounce on key 2");
    for (int k = 0; k < 10; k++) begin
      applyStimulus((k % 2 == 0) ? 4'b1011 : 4'b1111);
      waitCycles(2);
    end
    applyStimulus(4'b1011);
    expectEvent(LAT, 4'b0100, 4'b0000, 4'b0100);
    waitCycles(10);
    checkOutput("level after bounce", int'(key_level), 4);
    applyStimulus(4'b1111);
    expectEvent(LAT, 4'b0000, 4'b0100, 4'b0000);
    waitCycles(10);

    $display("[TB] reset mid-count on key 3");
    applyStimulus(4'b0111);
    waitCycles(4);
    checkOutput("level at count 2", int'(key_level), 0);
    reset = 1'b1;
    waitCycles(2);
    checkOutput("mid-count reset level", int'(key_level), 0);
    checkOutput("mid-count reset press", int'(key_press), 0);
    checkOutput("mid-count reset release", int'(key_release), 0);
    reset = 1'b0;
    expectEvent(LAT, 4'b1000, 4'b0000, 4'b1000);
    waitCycles(10);
    applyStimulus(4'b1111);
    expectEvent(LAT, 4'b0000, 4'b1000, 4'b0000);
    waitCycles(10);

    $display("[TB] all keys pressed together");
    applyStimulus(4'b0000);
    expectEvent(LAT, 4'b1111, 4'b0000, 4'b1111);
    waitCycles(10);
    checkOutput("level all pressed", int'(key_level), 15);
    reset = 1'b1;
    waitCycles(2);
    checkOutput("held-key reset level", int'(key_level), 0);
    reset = 1'b0;
    expectEvent(LAT, 4'b1111, 4'b0000, 4'b1111);
    waitCycles(10);
    applyStimulus(4'b1111);
    expectEvent(LAT, 4'b0000, 4'b1111, 4'b0000);
    waitCycles(12);

    checkOutput("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
